// File: rtl/blue_exec_unit.sv
// Blue CPU execution unit: registered ALU ops, multi-cycle SHRN and optional shift-add MUL.
// Optional feature macro: BLUE_EXEC_MUL_EN (compiles in MUL, opcode 10, and the MULT state).
module blue_exec_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       znc_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [2:0]       znc_out,
    output logic [1:0]       dbg_state
);
    // Handshake: start is sampled on a rising edge only while busy=0; done is a
    // one-cycle pulse at the edge results land, and busy falls at that same edge.
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_EXCH = 4'd8;
    localparam logic [3:0] OP_SHRN = 4'd9;
`ifdef BLUE_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef BLUE_EXEC_MUL_EN
        S_MULT  = 2'd2,
`endif
        S_SHIFT = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   a_out_q, a_out_d;
    logic [WIDTH-1:0]   b_out_q, b_out_d;
    logic [2:0]         znc_q, znc_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef BLUE_EXEC_MUL_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   mul_hi;
`endif

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_a;
    logic [WIDTH-1:0]   res_b;
    logic               res_c;
    logic               upd_zn;
    logic [CNT_W-1:0]   shamt;
    logic [WIDTH-1:0]   shifted;

    assign sum   = {1'b0, a_in} + {1'b0, b_in};
    assign diff  = {1'b0, a_in} - {1'b0, b_in};
    assign shamt = b_in[CNT_W-1:0];

    // Single-cycle result path, straight from the live inputs.
    always_comb begin
        res_a  = a_in;
        res_b  = b_in;
        res_c  = znc_in[0];
        upd_zn = 1'b0;
        case (opcode)
            OP_ADD:  begin res_a = sum[WIDTH-1:0];  res_c = sum[WIDTH];  upd_zn = 1'b1; end
            OP_SUB:  begin res_a = diff[WIDTH-1:0]; res_c = diff[WIDTH]; upd_zn = 1'b1; end
            OP_OR:   begin res_a = a_in | b_in; upd_zn = 1'b1; end
            OP_AND:  begin res_a = a_in & b_in; upd_zn = 1'b1; end
            OP_XOR:  begin res_a = a_in ^ b_in; upd_zn = 1'b1; end
            OP_SHR:  begin res_a = a_in >> 1; res_c = a_in[0]; upd_zn = 1'b1; end
            OP_MOV:  res_b = a_in;
            OP_EXCH: begin res_a = b_in; res_b = a_in; end
            OP_SHRN: upd_zn = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        znc_d   = znc_q;
        work_d  = work_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        shifted = work_q >> 1;
`ifdef BLUE_EXEC_MUL_EN
        hi_d    = hi_q;
        mul_sum = {1'b0, hi_q} + {1'b0, (work_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], work_q[WIDTH-1:1]};
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_SHRN && shamt != '0) begin
                        state_d = S_SHIFT;
                        busy_d  = 1'b1;
                        work_d  = a_in;
                        opb_d   = b_in;
                        cnt_d   = shamt;
`ifdef BLUE_EXEC_MUL_EN
                    end else if (opcode == OP_MUL) begin
                        state_d = S_MULT;
                        busy_d  = 1'b1;
                        work_d  = a_in;
                        hi_d    = '0;
                        opb_d   = b_in;
                        cnt_d   = '1;
`endif
                    end else begin
                        a_out_d = res_a;
                        b_out_d = res_b;
                        znc_d   = upd_zn ? {res_a == '0, res_a[WIDTH-1], res_c} : znc_in;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    a_out_d = shifted;
                    b_out_d = opb_q;
                    znc_d   = {shifted == '0, shifted[WIDTH-1], work_q[0]};
                end
            end
`ifdef BLUE_EXEC_MUL_EN
            // {hi, work} is the 2*WIDTH accumulator; work starts as the multiplier.
            S_MULT: begin
                hi_d   = mul_hi;
                work_d = mul_lo;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    a_out_d = mul_lo;
                    b_out_d = mul_hi;
                    znc_d   = {mul_lo == '0, mul_lo[WIDTH-1], mul_hi != '0};
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
            znc_q   <= 3'b000;
            work_q  <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
`ifdef BLUE_EXEC_MUL_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            znc_q   <= znc_d;
            work_q  <= work_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
`ifdef BLUE_EXEC_MUL_EN
            hi_q    <= hi_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign znc_out   = znc_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_blue_exec_unit.sv
// Directed bench for blue_exec_unit: back-to-back vector table plus multi-cycle sequences.
module tb_blue_exec_unit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] a_in, b_in;
    logic [2:0]   znc_in;
    logic         busy, done;
    logic [W-1:0] a_out, b_out;
    logic [2:0]   znc_out;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    blue_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .znc_in(znc_in),
        .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
        .znc_out(znc_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   znc;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [2:0]   ez;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] znc,
                          input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic [2:0] ez, input int lat);
        int cycles;
        @(negedge clk);
        opcode = op; a_in = a; b_in = b; znc_in = znc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_in = ~a; b_in = ~b; znc_in = ~znc;
        chk({name, "_busy_after_start"}, 32'(busy), 32'(lat > 1));
        wait_done(cycles);
        chk({name, "_latency"}, 32'(cycles), 32'(lat));
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({name, "_a_out"}, 32'(a_out), 32'(ea));
        chk({name, "_b_out"}, 32'(b_out), 32'(eb));
        chk({name, "_znc_out"}, 32'(znc_out), 32'(ez));
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cycles;
        // op, a, b, znc_in, expected a_out, b_out, znc_out
        vecs[0]  = '{4'd1,  16'hFFFF, 16'h0001, 3'b000, 16'h0000, 16'h0001, 3'b101};
        vecs[1]  = '{4'd2,  16'h0003, 16'h0005, 3'b000, 16'hFFFE, 16'h0005, 3'b011};
        vecs[2]  = '{4'd8,  16'hFFFE, 16'h0005, 3'b010, 16'h0005, 16'hFFFE, 3'b010};
        vecs[3]  = '{4'd3,  16'h00F0, 16'h0F00, 3'b001, 16'h0FF0, 16'h0F00, 3'b001};
        vecs[4]  = '{4'd4,  16'h00F0, 16'h0F00, 3'b001, 16'h0000, 16'h0F00, 3'b101};
        vecs[5]  = '{4'd5,  16'hF0F0, 16'h0FF0, 3'b000, 16'hFF00, 16'h0FF0, 3'b010};
        vecs[6]  = '{4'd6,  16'h0003, 16'h1234, 3'b000, 16'h0001, 16'h1234, 3'b001};
        vecs[7]  = '{4'd6,  16'h8000, 16'h0000, 3'b001, 16'h4000, 16'h0000, 3'b000};
        vecs[8]  = '{4'd7,  16'h8000, 16'h1111, 3'b110, 16'h8000, 16'h8000, 3'b110};
        vecs[9]  = '{4'd0,  16'h1234, 16'h5678, 3'b111, 16'h1234, 16'h5678, 3'b111};
        vecs[10] = '{4'd15, 16'hABCD, 16'h0000, 3'b010, 16'hABCD, 16'h0000, 3'b010};
        vecs[11] = '{4'd9,  16'h8001, 16'h0010, 3'b001, 16'h8001, 16'h0010, 3'b011};
        vecs[12] = '{4'd1,  16'h7FFF, 16'h0001, 3'b001, 16'h8000, 16'h0001, 3'b010};
        vecs[13] = '{4'd2,  16'h0005, 16'h0005, 3'b011, 16'h0000, 16'h0005, 3'b100};
        vecs[14] = '{4'd5,  16'hAAAA, 16'hAAAA, 3'b001, 16'h0000, 16'hAAAA, 3'b101};

        reset = 1'b1; start = 1'b0; opcode = '0; a_in = '0; b_in = '0; znc_in = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_a_out", 32'(a_out), 32'd0);
        chk("reset_b_out", 32'(b_out), 32'd0);
        chk("reset_znc_out", 32'(znc_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back single-cycle ops: start held high, one result per cycle.
        foreach (vecs[i]) begin
            @(negedge clk);
            opcode = vecs[i].op; a_in = vecs[i].a; b_in = vecs[i].b;
            znc_in = vecs[i].znc; start = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_a_out", i), 32'(a_out), 32'(vecs[i].ea));
            chk($sformatf("v%0d_b_out", i), 32'(b_out), 32'(vecs[i].eb));
            chk($sformatf("v%0d_znc_out", i), 32'(znc_out), 32'(vecs[i].ez));
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_done_drops", 32'(done), 32'd0);

        // SHRN n=4 with a start issued while busy: ignored, not queued.
        @(negedge clk);
        opcode = 4'd9; a_in = 16'h8001; b_in = 16'h0004; znc_in = 3'b111; start = 1'b1;
        @(posedge clk); #1;
        chk("shrn4_busy", 32'(busy), 32'd1);
        chk("shrn4_no_early_done", 32'(done), 32'd0);
        @(negedge clk);
        opcode = 4'd1; a_in = 16'h0001; b_in = 16'h0001; znc_in = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        cycles = 2;
        @(negedge clk);
        start = 1'b0; a_in = 16'hFFFF;
        while (done !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("shrn4_latency", 32'(cycles), 32'd5);
        chk("shrn4_a_out", 32'(a_out), 32'h0800);
        chk("shrn4_b_out", 32'(b_out), 32'h0004);
        chk("shrn4_znc_out", 32'(znc_out), 32'b000);
        chk("shrn4_busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("shrn4_ignored_start", 32'(done), 32'd0);
        chk("shrn4_outputs_held", 32'(a_out), 32'h0800);

        run_op("shrn1",  4'd9, 16'h0003, 16'h0001, 3'b000, 16'h0001, 16'h0001, 3'b001, 2);
        run_op("shrn15", 4'd9, 16'hFFFF, 16'h000F, 3'b000, 16'h0001, 16'h000F, 3'b001, 16);
        run_op("shrn0",  4'd9, 16'h1234, 16'h0000, 3'b110, 16'h1234, 16'h0000, 3'b000, 1);
`ifdef BLUE_EXEC_MUL_EN
        run_op("mul_a",  4'd10, 16'h0100, 16'h0100, 3'b000, 16'h0000, 16'h0001, 3'b101, 17);
        run_op("mul_b",  4'd10, 16'hFFFF, 16'hFFFF, 3'b110, 16'h0001, 16'hFFFE, 3'b001, 17);
        run_op("mul_c",  4'd10, 16'h0003, 16'h0005, 3'b111, 16'h000F, 16'h0000, 3'b000, 17);
`else
        run_op("mul_a",  4'd10, 16'h0100, 16'h0100, 3'b000, 16'h0100, 16'h0100, 3'b000, 1);
        run_op("mul_b",  4'd10, 16'hFFFF, 16'hFFFF, 3'b110, 16'hFFFF, 16'hFFFF, 3'b110, 1);
`endif

        // Reset in cycle 8 of a MUL discards it and zeroes everything.
        @(negedge clk);
        opcode = 4'd10; a_in = 16'h0100; b_in = 16'h0100; znc_in = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_a_out", 32'(a_out), 32'd0);
        chk("midrst_b_out", 32'(b_out), 32'd0);
        chk("midrst_znc_out", 32'(znc_out), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            chk("midrst_no_stale_done", 32'(done), 32'd0);
        end
        run_op("post_rst_add", 4'd1, 16'h0002, 16'h0003, 3'b000, 16'h0005, 16'h0003, 3'b000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
